// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared core types (control bundle, RS entry) and widths.
package reservation_station_pkg;
  localparam int REG_VAL_WIDTH = 32;
  localparam int PHYSICAL_REG_NUM_WIDTH = 6;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic [2:0] fu_sel;
  } control_t;
  typedef struct packed {
    logic                              valid;
    control_t                          control;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] src1_tag;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] src2_tag;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_tag;
    logic [REG_VAL_WIDTH-1:0]          src1_val;
    logic [REG_VAL_WIDTH-1:0]          src2_val;
    logic                              src1_ready;
    logic                              src2_ready;
    logic [REG_VAL_WIDTH-1:0]          immediate;
  } rs_entry_t;
endpackage

// File: rtl/reservation_station_rs_select.sv
// rs_select: one-hot issue grant; oldest-first when RS_OLDEST_FIRST_EN, else lowest index.
module rs_select #(
  parameter int N = 4
`ifdef RS_OLDEST_FIRST_EN
  , parameter int AW = 2
`endif
) (
  input  logic [N-1:0]          eligible,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [N-1:0][AW-1:0]  age,
`endif
  output logic [N-1:0]          grant,
  output logic                  valid
);
`ifdef RS_OLDEST_FIRST_EN
  logic          found;
  logic [AW-1:0] best;
  always_comb begin
    grant = '0;
    found = 1'b0;
    best = '0;
    for (int i = 0; i < N; i++)
      if (eligible[i] && (!found || age[i] > best)) begin
        found = 1'b1;
        best = age[i];
        grant = '0;
        grant[i] = 1'b1;
      end
  end
  assign valid = found;
`else
  assign grant = eligible & (~eligible + 1'b1);
  assign valid = |eligible;
`endif
endmodule

// File: rtl/reservation_station.sv
// reservation_station: dispatch/wakeup/issue buffer; define RS_OLDEST_FIRST_EN for age-based select.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              new_valid_inst,
  input  control_t                          control,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] src_reg1_addr,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] src_reg2_addr,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr,
  input  logic [REG_VAL_WIDTH-1:0]          src_reg1_val,
  input  logic [REG_VAL_WIDTH-1:0]          src_reg2_val,
  input  logic [REG_VAL_WIDTH-1:0]          immediate,
  input  logic                              src1_ready_in,
  input  logic                              src2_ready_in,
  input  logic                              cdb_valid,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_tag,
  input  logic [REG_VAL_WIDTH-1:0]          cdb_value,
  output logic                              rs_full,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output control_t                          issue_control,
  output logic [REG_VAL_WIDTH-1:0]          issue_src1_val,
  output logic [REG_VAL_WIDTH-1:0]          issue_src2_val,
  output logic [REG_VAL_WIDTH-1:0]          issue_immediate,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] issue_dst_reg_addr
);
  rs_entry_t           entry_q [RS_DEPTH];
  rs_entry_t           entry_d [RS_DEPTH];
  rs_entry_t           sel;
  rs_entry_t           new_entry;
  logic [RS_DEPTH-1:0] valid_vec, free_oh, eligible, grant;
  logic                alloc, fire, hit1, hit2;
`ifdef RS_OLDEST_FIRST_EN
  localparam int AW = $clog2(RS_DEPTH);
  logic [RS_DEPTH-1:0][AW-1:0] age_q, age_d;
`endif
  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_vec
    assign valid_vec[g] = entry_q[g].valid;
    assign eligible[g] = entry_q[g].valid & entry_q[g].src1_ready & entry_q[g].src2_ready;
  end
  assign rs_full = &valid_vec;
  assign free_oh = ~valid_vec & (valid_vec + 1'b1);
  assign alloc = new_valid_inst & ~rs_full;
  assign fire = issue_valid & issue_ready;
  assign hit1 = cdb_valid && cdb_tag == src_reg1_addr;
  assign hit2 = cdb_valid && cdb_tag == src_reg2_addr;
  rs_select #(
    .N(RS_DEPTH)
`ifdef RS_OLDEST_FIRST_EN
    , .AW(AW)
`endif
  ) u_select (
    .eligible(eligible),
`ifdef RS_OLDEST_FIRST_EN
    .age(age_q),
`endif
    .grant(grant),
    .valid(issue_valid)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (grant[i]) sel = entry_q[i];
  end
  assign issue_control = sel.control;
  assign issue_src1_val = sel.src1_val;
  assign issue_src2_val = sel.src2_val;
  assign issue_immediate = sel.immediate;
  assign issue_dst_reg_addr = sel.dst_tag;
  // A source already marked ready keeps its dispatch value even if the CDB tag matches.
  always_comb begin
    new_entry = '0;
    new_entry.valid = 1'b1;
    new_entry.control = control;
    new_entry.src1_tag = src_reg1_addr;
    new_entry.src2_tag = src_reg2_addr;
    new_entry.dst_tag = dst_reg_addr;
    new_entry.src1_ready = src1_ready_in | hit1;
    new_entry.src2_ready = src2_ready_in | hit2;
    new_entry.src1_val = (!src1_ready_in && hit1) ? cdb_value : src_reg1_val;
    new_entry.src2_val = (!src2_ready_in && hit2) ? cdb_value : src_reg2_val;
    new_entry.immediate = immediate;
  end
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (cdb_valid && entry_q[i].valid && !entry_q[i].src1_ready && entry_q[i].src1_tag == cdb_tag) begin
        entry_d[i].src1_val = cdb_value;
        entry_d[i].src1_ready = 1'b1;
      end
      if (cdb_valid && entry_q[i].valid && !entry_q[i].src2_ready && entry_q[i].src2_tag == cdb_tag) begin
        entry_d[i].src2_val = cdb_value;
        entry_d[i].src2_ready = 1'b1;
      end
      if (fire && grant[i]) entry_d[i].valid = 1'b0;
      if (alloc && free_oh[i]) entry_d[i] = new_entry;
    end
  end
`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < RS_DEPTH; i++)
      age_d[i] = !alloc ? age_q[i] :
                 free_oh[i] ? '0 :
                 (entry_q[i].valid && age_q[i] != AW'(RS_DEPTH - 1)) ? age_q[i] + 1'b1 : age_q[i];
  end
  always_ff @(posedge clk)
    if (reset) age_q <= '0;
    else age_q <= age_d;
`endif
  always_ff @(posedge clk)
    if (reset) entry_q <= '{default: '0};
    else entry_q <= entry_d;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed self-checking bench for reservation_station.
module tb_reservation_station;
  import reservation_station_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic new_valid_inst = 1'b0, src1_ready_in = 1'b0, src2_ready_in = 1'b0;
  control_t control = '0, issue_control;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] src_reg1_addr = '0, src_reg2_addr = '0, dst_reg_addr = '0;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_tag = '0, issue_dst_reg_addr;
  logic [REG_VAL_WIDTH-1:0] src_reg1_val = '0, src_reg2_val = '0, immediate = '0, cdb_value = '0;
  logic [REG_VAL_WIDTH-1:0] issue_src1_val, issue_src2_val, issue_immediate;
  logic cdb_valid = 1'b0, issue_ready = 1'b0, rs_full, issue_valid;
  int compared = 0, mismatched = 0;

  reservation_station #(.RS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .new_valid_inst(new_valid_inst), .control(control),
    .src_reg1_addr(src_reg1_addr), .src_reg2_addr(src_reg2_addr), .dst_reg_addr(dst_reg_addr),
    .src_reg1_val(src_reg1_val), .src_reg2_val(src_reg2_val), .immediate(immediate),
    .src1_ready_in(src1_ready_in), .src2_ready_in(src2_ready_in),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_control(issue_control), .issue_src1_val(issue_src1_val),
    .issue_src2_val(issue_src2_val), .issue_immediate(issue_immediate),
    .issue_dst_reg_addr(issue_dst_reg_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic r1, input logic r2, input logic [5:0] t1, input logic [5:0] t2,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [5:0] dst);
    new_valid_inst = 1'b1;
    src1_ready_in = r1;
    src2_ready_in = r2;
    src_reg1_addr = t1;
    src_reg2_addr = t2;
    src_reg1_val = v1;
    src_reg2_val = v2;
    dst_reg_addr = dst;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("reset_full", 64'(rs_full), 0);
    chk("reset_issue_valid", 64'(issue_valid), 0);
    chk("reset_src1", 64'(issue_src1_val), 0);
    chk("reset_dst", 64'(issue_dst_reg_addr), 0);
    // Both sources ready: visible one cycle after allocation.
    control = '{alu_op: 4'h5, use_imm: 1'b1, fu_sel: 3'h2};
    immediate = 32'h1234;
    dispatch(1, 1, 6'd1, 6'd2, 32'd5, 32'd7, 6'd12);
    chk("pre_alloc_valid", 64'(issue_valid), 0);
    tick();
    new_valid_inst = 1'b0;
    chk("basic_valid", 64'(issue_valid), 1);
    chk("basic_src1", 64'(issue_src1_val), 5);
    chk("basic_src2", 64'(issue_src2_val), 7);
    chk("basic_dst", 64'(issue_dst_reg_addr), 12);
    chk("basic_ctrl", 64'(issue_control), 64'h5A);
    chk("basic_imm", 64'(issue_immediate), 64'h1234);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("basic_freed", 64'(issue_valid), 0);
    // Wakeup via CDB two cycles after dispatch.
    dispatch(0, 1, 6'd9, 6'd4, 32'd0, 32'd1, 6'd13);
    tick();
    new_valid_inst = 1'b0;
    chk("wait_c1", 64'(issue_valid), 0);
    tick();
    chk("wait_c2", 64'(issue_valid), 0);
    cdb_valid = 1'b1;
    cdb_tag = 6'd9;
    cdb_value = 32'h55;
    chk("no_same_cycle_wake", 64'(issue_valid), 0);
    tick();
    cdb_valid = 1'b0;
    chk("wake_valid", 64'(issue_valid), 1);
    chk("wake_src1", 64'(issue_src1_val), 64'h55);
    chk("wake_dst", 64'(issue_dst_reg_addr), 13);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("wake_freed", 64'(issue_valid), 0);
    // CDB broadcast concurrent with dispatch.
    dispatch(1, 0, 6'd0, 6'd3, 32'd2, 32'h11, 6'd14);
    cdb_valid = 1'b1;
    cdb_tag = 6'd3;
    cdb_value = 32'hAA;
    tick();
    new_valid_inst = 1'b0;
    cdb_valid = 1'b0;
    chk("bypass_valid", 64'(issue_valid), 1);
    chk("bypass_src2", 64'(issue_src2_val), 64'hAA);
    chk("bypass_src1", 64'(issue_src1_val), 2);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    // Fill, overflow dispatch ignored, drain in order.
    for (int i = 0; i < 4; i++) begin
      dispatch(1, 1, 6'd0, 6'd0, 32'(10 + i), 32'd0, 6'(20 + i));
      tick();
    end
    chk("full_set", 64'(rs_full), 1);
    dispatch(1, 1, 6'd0, 6'd0, 32'd99, 32'd0, 6'd30);
    tick();
    new_valid_inst = 1'b0;
    chk("full_hold", 64'(rs_full), 1);
    chk("full_first_dst", 64'(issue_dst_reg_addr), 20);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("full_cleared", 64'(rs_full), 0);
    issue_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("drain_dst", 64'(issue_dst_reg_addr), 64'(20 + i));
      tick();
    end
    issue_ready = 1'b0;
    chk("drain_empty", 64'(issue_valid), 0);
    // Age ordering: A slot0, B slot1, issue A, C into slot0.
    dispatch(1, 1, 6'd0, 6'd0, 32'd0, 32'd0, 6'd1);
    tick();
    dispatch(1, 1, 6'd0, 6'd0, 32'd0, 32'd0, 6'd2);
    tick();
    new_valid_inst = 1'b0;
    chk("order_a", 64'(issue_dst_reg_addr), 1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    dispatch(1, 1, 6'd0, 6'd0, 32'd0, 32'd0, 6'd3);
    tick();
    new_valid_inst = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    chk("order_first", 64'(issue_dst_reg_addr), 2);
`else
    chk("order_first", 64'(issue_dst_reg_addr), 3);
`endif
    issue_ready = 1'b1;
    tick();
`ifdef RS_OLDEST_FIRST_EN
    chk("order_second", 64'(issue_dst_reg_addr), 3);
`else
    chk("order_second", 64'(issue_dst_reg_addr), 2);
`endif
    tick();
    issue_ready = 1'b0;
    chk("order_empty", 64'(issue_valid), 0);
    // Same-cycle allocate and issue both take effect.
    dispatch(1, 1, 6'd0, 6'd0, 32'd0, 32'd0, 6'd40);
    tick();
    dispatch(1, 1, 6'd0, 6'd0, 32'd0, 32'd0, 6'd41);
    issue_ready = 1'b1;
    tick();
    new_valid_inst = 1'b0;
    chk("alloc_issue_dst", 64'(issue_dst_reg_addr), 41);
    tick();
    issue_ready = 1'b0;
    chk("alloc_issue_empty", 64'(issue_valid), 0);
    // Reset with pending entries, dispatch and CDB.
    for (int i = 0; i < 3; i++) begin
      dispatch(0, 1, 6'd5, 6'd0, 32'd0, 32'd0, 6'(50 + i));
      tick();
    end
    reset = 1'b1;
    cdb_valid = 1'b1;
    cdb_tag = 6'd5;
    cdb_value = 32'h77;
    tick();
    reset = 1'b0;
    new_valid_inst = 1'b0;
    chk("rst_full", 64'(rs_full), 0);
    chk("rst_issue_valid", 64'(issue_valid), 0);
    tick();
    cdb_valid = 1'b0;
    chk("rst_no_old_issue", 64'(issue_valid), 0);
    chk("rst_src1_zero", 64'(issue_src1_val), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
